jtag_tap_sequencer: RTL and testbench



---
 rtl/jtag_tap_sequencer.sv | 117 +++++++++++
 tb/tb_jtag_tap_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_sequencer.sv
// IEEE 1149.1 TAP controller: TMS-driven state machine with Moore-decoded IR/DR
// capture/shift/update enables, TDO mux control and a saturating shifted-bit counter.
module jtag_tap_sequencer #(
  parameter int CNT_W    = 8,
  parameter int TLR_HOLD = 5
) (
  input  logic             tck,
  input  logic             reset,
  input  logic             tms,
  output logic [3:0]       state,
  output logic             tlr,
  output logic             capture_ir,
  output logic             shift_ir,
  output logic             update_ir,
  output logic             capture_dr,
  output logic             shift_dr,
  output logic             update_dr,
  output logic             select_ir,
  output logic             tdo_en,
  output logic [CNT_W-1:0] shift_count
);

  localparam logic [3:0] TLR      = 4'hF;
  localparam logic [3:0] RTI      = 4'hC;
  localparam logic [3:0] SEL_DR   = 4'h7;
  localparam logic [3:0] CAP_DR   = 4'h6;
  localparam logic [3:0] SH_DR    = 4'h2;
  localparam logic [3:0] EX1_DR   = 4'h1;
  localparam logic [3:0] PAUSE_DR = 4'h3;
  localparam logic [3:0] EX2_DR   = 4'h0;
  localparam logic [3:0] UP_DR    = 4'h5;
  localparam logic [3:0] SEL_IR   = 4'h4;
  localparam logic [3:0] CAP_IR   = 4'hE;
  localparam logic [3:0] SH_IR    = 4'hA;
  localparam logic [3:0] EX1_IR   = 4'h9;
  localparam logic [3:0] PAUSE_IR = 4'hB;
  localparam logic [3:0] EX2_IR   = 4'h8;
  localparam logic [3:0] UP_IR    = 4'hD;

  localparam int HOLD_W = $clog2(TLR_HOLD + 1);

  logic [3:0]        r_state;
  logic [3:0]        w_fsm_next;
  logic [3:0]        w_next_state;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_next;
  logic [CNT_W-1:0]  r_shift_cnt;
  logic              w_in_shift;
  logic              w_to_capture;

  always_comb begin
    w_fsm_next = TLR;
    case (r_state)
      TLR:      w_fsm_next = tms ? TLR      : RTI;
      RTI:      w_fsm_next = tms ? SEL_DR   : RTI;
      SEL_DR:   w_fsm_next = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   w_fsm_next = tms ? EX1_DR   : SH_DR;
      SH_DR:    w_fsm_next = tms ? EX1_DR   : SH_DR;
      EX1_DR:   w_fsm_next = tms ? UP_DR    : PAUSE_DR;
      PAUSE_DR: w_fsm_next = tms ? EX2_DR   : PAUSE_DR;
      EX2_DR:   w_fsm_next = tms ? UP_DR    : SH_DR;
      UP_DR:    w_fsm_next = tms ? SEL_DR   : RTI;
      SEL_IR:   w_fsm_next = tms ? TLR      : CAP_IR;
      CAP_IR:   w_fsm_next = tms ? EX1_IR   : SH_IR;
      SH_IR:    w_fsm_next = tms ? EX1_IR   : SH_IR;
      EX1_IR:   w_fsm_next = tms ? UP_IR    : PAUSE_IR;
      PAUSE_IR: w_fsm_next = tms ? EX2_IR   : PAUSE_IR;
      EX2_IR:   w_fsm_next = tms ? UP_IR    : SH_IR;
      UP_IR:    w_fsm_next = tms ? SEL_DR   : RTI;
      default:  w_fsm_next = TLR;
    endcase
  end

  // Counts the current sample too, so the guard fires on the TLR_HOLD-th high edge.
  always_comb begin
    if (!tms)
      w_hold_next = '0;
    else if (r_hold_cnt == HOLD_W'(TLR_HOLD))
      w_hold_next = r_hold_cnt;
    else
      w_hold_next = r_hold_cnt + HOLD_W'(1);
  end

  assign w_next_state = (w_hold_next == HOLD_W'(TLR_HOLD)) ? TLR : w_fsm_next;
  assign w_in_shift   = (r_state == SH_DR) || (r_state == SH_IR);
  assign w_to_capture = (w_next_state == CAP_DR) || (w_next_state == CAP_IR);

  always_ff @(posedge tck) begin
    if (reset) begin
      r_state     <= TLR;
      r_hold_cnt  <= '0;
      r_shift_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_hold_cnt <= w_hold_next;
      if (w_to_capture)
        r_shift_cnt <= '0;
      else if (w_in_shift && (r_shift_cnt != '1))
        r_shift_cnt <= r_shift_cnt + CNT_W'(1);
    end
  end

  assign state       = r_state;
  assign tlr         = (r_state == TLR);
  assign capture_ir  = (r_state == CAP_IR);
  assign shift_ir    = (r_state == SH_IR);
  assign update_ir   = (r_state == UP_IR);
  assign capture_dr  = (r_state == CAP_DR);
  assign shift_dr    = (r_state == SH_DR);
  assign update_dr   = (r_state == UP_DR);
  assign select_ir   = (r_state == SEL_IR) || (r_state == CAP_IR) || (r_state == SH_IR) ||
                       (r_state == EX1_IR) || (r_state == PAUSE_IR) || (r_state == EX2_IR) ||
                       (r_state == UP_IR);
  assign tdo_en      = w_in_shift;
  assign shift_count = r_shift_cnt;

endmodule

// File: tb/tb_jtag_tap_sequencer.sv
// Self-checking bench for jtag_tap_sequencer: directed scans plus randomized TMS/reset
// compared against a table-driven TAP model; a second instance checks counter saturation.
module tb_jtag_tap_sequencer;

  logic       tck = 1'b0;
  logic       reset = 1'b1;
  logic       tms = 1'b0;

  logic [3:0] state, s_state;
  logic       tlr, capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr;
  logic       select_ir, tdo_en;
  logic       s_tlr, s_capture_ir, s_shift_ir, s_update_ir, s_capture_dr, s_shift_dr;
  logic       s_update_dr, s_select_ir, s_tdo_en;
  logic [7:0] shift_count;
  logic [2:0] s_shift_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: next-state tables indexed by state code, plus unbounded scan count.
  int t0 [16];
  int t1 [16];
  int m_state = 15;
  int m_cnt   = 0;

  jtag_tap_sequencer #(.CNT_W(8), .TLR_HOLD(5)) dut (
    .tck(tck), .reset(reset), .tms(tms), .state(state), .tlr(tlr),
    .capture_ir(capture_ir), .shift_ir(shift_ir), .update_ir(update_ir),
    .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
    .select_ir(select_ir), .tdo_en(tdo_en), .shift_count(shift_count)
  );

  jtag_tap_sequencer #(.CNT_W(3), .TLR_HOLD(5)) dut_s (
    .tck(tck), .reset(reset), .tms(tms), .state(s_state), .tlr(s_tlr),
    .capture_ir(s_capture_ir), .shift_ir(s_shift_ir), .update_ir(s_update_ir),
    .capture_dr(s_capture_dr), .shift_dr(s_shift_dr), .update_dr(s_update_dr),
    .select_ir(s_select_ir), .tdo_en(s_tdo_en), .shift_count(s_shift_count)
  );

  always #5 tck = ~tck;

  task automatic init_model();
    t0[15] = 12; t1[15] = 15;
    t0[12] = 12; t1[12] = 7;
    t0[7]  = 6;  t1[7]  = 4;
    t0[4]  = 14; t1[4]  = 15;
    t0[6]  = 2;  t1[6]  = 1;
    t0[2]  = 2;  t1[2]  = 1;
    t0[1]  = 3;  t1[1]  = 5;
    t0[3]  = 3;  t1[3]  = 0;
    t0[0]  = 2;  t1[0]  = 5;
    t0[5]  = 12; t1[5]  = 7;
    t0[14] = 10; t1[14] = 9;
    t0[10] = 10; t1[10] = 9;
    t0[9]  = 11; t1[9]  = 13;
    t0[11] = 11; t1[11] = 8;
    t0[8]  = 10; t1[8]  = 13;
    t0[13] = 12; t1[13] = 7;
  endtask

  // Drive one TCK cycle and advance the model; outputs are then sampled 1ns after the edge.
  task automatic step(input logic t, input logic r);
    int nxt;
    tms   = t;
    reset = r;
    @(posedge tck);
    #1;
    if (r) begin
      m_state = 15;
      m_cnt   = 0;
    end else begin
      nxt = t ? t1[m_state] : t0[m_state];
      if (nxt == 6 || nxt == 14)
        m_cnt = 0;
      else if (m_state == 2 || m_state == 10)
        m_cnt = m_cnt + 1;
      m_state = nxt;
    end
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1);
    n_checks++;
    if (state !== 4'hF || tlr !== 1'b1)
      $display("FAIL reset_state: state=%h tlr=%b, required state=f tlr=1", state, tlr);
    else n_pass++;
    n_checks++;
    if ({capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr, select_ir, tdo_en} !== 8'h00
        || shift_count !== 8'd0)
      $display("FAIL reset_outputs: enables=%b count=%0d, required all 0",
               {capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr, select_ir, tdo_en},
               shift_count);
    else n_pass++;
    step(1'b0, 1'b0);
    n_checks++;
    if (state !== 4'hC || tlr !== 1'b0 || tdo_en !== 1'b0)
      $display("FAIL reset_to_rti: state=%h tlr=%b tdo_en=%b, required c 0 0", state, tlr, tdo_en);
    else n_pass++;
  endtask

  task automatic test_ir_scan();
    logic       seq [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] exp [9] = '{4'h7, 4'h4, 4'hE, 4'hA, 4'hA, 4'hA, 4'hA, 4'h9, 4'hD};
    int sh_cycles = 0;
    int up_cycles = 0;
    int sel_bad   = 0;
    for (int i = 0; i < 9; i++) begin
      step(seq[i], 1'b0);
      n_checks++;
      if (state !== exp[i])
        $display("FAIL ir_state[%0d]: state=%h, required %h", i, state, exp[i]);
      else n_pass++;
      if (shift_ir) sh_cycles++;
      if (update_ir) up_cycles++;
      if (i >= 1 && select_ir !== 1'b1) sel_bad++;
      if (exp[i] == 4'h9 || exp[i] == 4'hD) begin
        n_checks++;
        if (shift_count !== 8'd4)
          $display("FAIL ir_count[%0d]: shift_count=%0d, required 4", i, shift_count);
        else n_pass++;
      end
    end
    n_checks++;
    if (sh_cycles != 4 || up_cycles != 1 || sel_bad != 0)
      $display("FAIL ir_enables: shift_ir cycles=%0d update_ir cycles=%0d select_ir gaps=%0d, required 4 1 0",
               sh_cycles, up_cycles, sel_bad);
    else n_pass++;
    step(1'b0, 1'b0);
  endtask

  task automatic test_dr_pause();
    logic       seq [12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] exp [12] = '{4'h7, 4'h6, 4'h2, 4'h2, 4'h1, 4'h3, 4'h3, 4'h0, 4'h2, 4'h2, 4'h1, 4'h5};
    int         cnt [12] = '{4, 0, 0, 1, 2, 2, 2, 2, 2, 3, 4, 4};
    for (int i = 0; i < 12; i++) begin
      step(seq[i], 1'b0);
      n_checks++;
      if (state !== exp[i] || shift_count !== 8'(cnt[i]))
        $display("FAIL dr_step[%0d]: state=%h count=%0d, required %h %0d",
                 i, state, shift_count, exp[i], cnt[i]);
      else n_pass++;
      n_checks++;
      if (tdo_en !== (exp[i] == 4'h2) || shift_dr !== (exp[i] == 4'h2) || select_ir !== 1'b0 ||
          update_dr !== (exp[i] == 4'h5) || capture_dr !== (exp[i] == 4'h6))
        $display("FAIL dr_enables[%0d]: tdo_en=%b shift_dr=%b sel=%b upd=%b cap=%b",
                 i, tdo_en, shift_dr, select_ir, update_dr, capture_dr);
      else n_pass++;
    end
  endtask

  task automatic test_tlr_hold();
    logic [3:0] exp [5] = '{4'h1, 4'h5, 4'h7, 4'h4, 4'hF};
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0);
      n_checks++;
      if (state !== exp[i] || tlr !== (i == 4) || shift_count !== 8'd2)
        $display("FAIL tms_high[%0d]: state=%h tlr=%b count=%0d, required %h %b 2",
                 i, state, tlr, shift_count, exp[i], (i == 4));
      else n_pass++;
    end
    step(1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0);
    n_checks++;
    if (s_shift_count !== 3'd7 || shift_count !== 8'd9)
      $display("FAIL sat_in_shift: narrow=%0d wide=%0d, required 7 9", s_shift_count, shift_count);
    else n_pass++;
    step(1'b1, 1'b0);
    n_checks++;
    if (s_state !== 4'h9 || s_shift_count !== 3'd7 || shift_count !== 8'd10)
      $display("FAIL sat_exit: state=%h narrow=%0d wide=%0d, required 9 7 10",
               s_state, s_shift_count, shift_count);
    else n_pass++;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    n_checks++;
    if (s_state !== 4'h6 || s_shift_count !== 3'd0 || shift_count !== 8'd0)
      $display("FAIL sat_recapture: state=%h narrow=%0d wide=%0d, required 6 0 0",
               s_state, s_shift_count, shift_count);
    else n_pass++;
  endtask

  task automatic test_reset_midscan();
    int upd = 0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    n_checks++;
    if (state !== 4'hA || shift_count !== 8'd1)
      $display("FAIL midscan_setup: state=%h count=%0d, required a 1", state, shift_count);
    else n_pass++;
    step(1'b0, 1'b1);
    if (update_ir) upd++;
    n_checks++;
    if (state !== 4'hF || shift_count !== 8'd0 || s_shift_count !== 3'd0)
      $display("FAIL midscan_reset: state=%h count=%0d, required f 0", state, shift_count);
    else n_pass++;
    step(1'b0, 1'b0);
    if (update_ir) upd++;
    n_checks++;
    if (state !== 4'hC || upd != 0)
      $display("FAIL midscan_after: state=%h update_ir pulses=%0d, required c 0", state, upd);
    else n_pass++;
  endtask

  task automatic test_random();
    logic t, r;
    logic exp_sel, exp_sh;
    logic [7:0] exp_en;
    int errs_st = 0;
    int errs_en = 0;
    int errs_ct = 0;
    for (int i = 0; i < 3000; i++) begin
      t = ($urandom_range(0, 99) < 35);
      r = ($urandom_range(0, 199) == 0);
      step(t, r);
      exp_sel = (m_state inside {4, 14, 10, 9, 11, 8, 13});
      exp_sh  = (m_state == 2 || m_state == 10);
      exp_en  = {m_state == 15, m_state == 14, m_state == 10, m_state == 13,
                 m_state == 6, m_state == 2, m_state == 5, exp_sel};
      n_checks++;
      if (state !== 4'(m_state) || s_state !== 4'(m_state)) begin
        errs_st++;
        if (errs_st <= 5)
          $display("FAIL rand_state[%0d]: state=%h narrow=%h, required %h", i, state, s_state, m_state);
      end else n_pass++;
      n_checks++;
      if ({tlr, capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr, select_ir} !== exp_en ||
          tdo_en !== exp_sh) begin
        errs_en++;
        if (errs_en <= 5)
          $display("FAIL rand_enables[%0d]: got %b/%b, required %b/%b", i,
                   {tlr, capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr, select_ir},
                   tdo_en, exp_en, exp_sh);
      end else n_pass++;
      n_checks++;
      if (shift_count !== 8'((m_cnt > 255) ? 255 : m_cnt) ||
          s_shift_count !== 3'((m_cnt > 7) ? 7 : m_cnt)) begin
        errs_ct++;
        if (errs_ct <= 5)
          $display("FAIL rand_count[%0d]: wide=%0d narrow=%0d, required scan count %0d (saturating)",
                   i, shift_count, s_shift_count, m_cnt);
      end else n_pass++;
    end
  endtask

  initial begin
    init_model();
    test_reset();
    test_ir_scan();
    test_dr_pause();
    test_tlr_hold();
    test_saturation();
    test_reset_midscan();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
